// File: rtl/instr_fetch.sv
// Fetch stage: issues in-order instruction memory requests from the PC and buffers returned words with their PC.
// A flush drops buffered entries and turns in-flight fetches into responses that are discarded.
module instr_fetch #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    input  logic                   pc_req_i,
    output logic                   pc_ack_o,
    input  logic                   flush_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    output logic                   instr_err_o
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_FULL = FIFO_DEPTH[CW-1:0];
    localparam logic [CW+1:0] DEPTH_W  = FIFO_DEPTH[CW+1:0];

    logic [INSTR_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  r_fifo_pc    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_fifo_err;
    logic [ADDR_WIDTH-1:0]  r_aq         [FIFO_DEPTH];
    logic [CW-1:0]          r_wptr;
    logic [CW-1:0]          r_rptr;
    logic [CW-1:0]          r_aq_wptr;
    logic [CW-1:0]          r_aq_rptr;
    logic [CW-1:0]          r_discard;

    logic [CW-1:0]          w_count;
    logic [CW-1:0]          w_outstanding;
    logic [CW+1:0]          w_used;
    logic                   w_space;
    logic                   w_aligned;
    logic                   w_idle;
    logic                   w_accept;
    logic                   w_mem_req;
    logic                   w_mem_ack;
    logic                   w_mis_ack;
    logic                   w_rsp_take;
    logic                   w_rsp_drop;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_valid;
    logic [CW-1:0]          w_flush_dec;
    logic [INSTR_WIDTH-1:0] w_push_instr;
    logic [ADDR_WIDTH-1:0]  w_push_pc;
    logic                   w_push_err;

    // Credit: buffered + in flight + still-to-be-discarded may never exceed the buffer depth.
    assign w_count       = r_wptr - r_rptr;
    assign w_outstanding = r_aq_wptr - r_aq_rptr;
    assign w_used        = {2'b00, w_count} + {2'b00, w_outstanding} + {2'b00, r_discard};
    assign w_space       = (w_used < DEPTH_W);
    assign w_aligned     = (pc_i[1:0] == 2'b00);
    assign w_idle        = (w_outstanding == CNT_ZERO) && (r_discard == CNT_ZERO);
    assign w_empty       = (w_count == CNT_ZERO);

    assign w_accept   = rst_n & pc_req_i & w_space & ~flush_i;
    assign w_mem_req  = w_accept & w_aligned;
    assign w_mem_ack  = w_mem_req & imem_gnt_i;
    assign w_mis_ack  = w_accept & ~w_aligned & w_idle;
    assign w_rsp_drop = imem_rvalid_i & (r_discard != CNT_ZERO);
    assign w_rsp_take = imem_rvalid_i & ~flush_i & (r_discard == CNT_ZERO) & (w_outstanding != CNT_ZERO);
    assign w_push     = w_rsp_take | w_mis_ack;
    assign w_valid    = rst_n & ~w_empty;
    assign w_pop      = w_valid & instr_ready_i & ~flush_i;
    assign w_flush_dec = (imem_rvalid_i && !w_idle) ? CNT_ONE : CNT_ZERO;

    // Select the FIFO entry being written: a memory response or a misaligned-fetch error entry.
    always_comb begin
        w_push_instr = {INSTR_WIDTH{1'b0}};
        w_push_pc    = pc_i;
        w_push_err   = 1'b1;
        if (w_rsp_take) begin
            w_push_instr = imem_rdata_i;
            w_push_pc    = r_aq[r_aq_rptr[PW-1:0]];
            w_push_err   = 1'b0;
        end else begin
            w_push_instr = {INSTR_WIDTH{1'b0}};
            w_push_pc    = pc_i;
            w_push_err   = 1'b1;
        end
    end

    // Pointers and the discard counter; flush wins over every other update in its cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr    <= CNT_ZERO;
            r_rptr    <= CNT_ZERO;
            r_aq_wptr <= CNT_ZERO;
            r_aq_rptr <= CNT_ZERO;
            r_discard <= CNT_ZERO;
        end else if (flush_i) begin
            r_wptr    <= CNT_ZERO;
            r_rptr    <= CNT_ZERO;
            r_aq_wptr <= CNT_ZERO;
            r_aq_rptr <= CNT_ZERO;
            r_discard <= r_discard + w_outstanding - w_flush_dec;
        end else begin
            if (w_push)     r_wptr    <= r_wptr + CNT_ONE;
            if (w_pop)      r_rptr    <= r_rptr + CNT_ONE;
            if (w_mem_ack)  r_aq_wptr <= r_aq_wptr + CNT_ONE;
            if (w_rsp_take) r_aq_rptr <= r_aq_rptr + CNT_ONE;
            if (w_rsp_drop) r_discard <= r_discard - CNT_ONE;
        end
    end

    // Entry storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wptr[PW-1:0]] <= w_push_instr;
            r_fifo_pc[r_wptr[PW-1:0]]    <= w_push_pc;
            r_fifo_err[r_wptr[PW-1:0]]   <= w_push_err;
        end
        if (w_mem_ack) begin
            r_aq[r_aq_wptr[PW-1:0]] <= pc_i;
        end
    end

    assign imem_req_o    = w_mem_req;
    assign imem_addr_o   = rst_n ? pc_i : {ADDR_WIDTH{1'b0}};
    assign pc_ack_o      = w_mem_ack | w_mis_ack;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_fifo_instr[r_rptr[PW-1:0]] : {INSTR_WIDTH{1'b0}};
    assign instr_pc_o    = w_valid ? r_fifo_pc[r_rptr[PW-1:0]] : {ADDR_WIDTH{1'b0}};
    assign instr_err_o   = w_valid ? r_fifo_err[r_rptr[PW-1:0]] : 1'b0;

    // A response with nothing requested is a memory protocol error; the credit scheme forbids overflow.
    a_rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid_i |-> !w_idle);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (w_push && !w_pop) |-> (w_count != CNT_FULL));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_pop |-> !w_empty);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-level reference model checks every output each cycle,
// and literal expectations pin the reset, stream, backpressure, flush, misaligned and stall scenarios.
module tb_instr_fetch;
    localparam int DEPTH = 2;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b0;
    logic [31:0] pc_i          = 32'h0;
    logic        pc_req_i      = 1'b0;
    logic        flush_i       = 1'b0;
    logic        imem_gnt_i    = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = 32'h0;
    logic        instr_ready_i = 1'b0;
    logic        pc_ack_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_err_o;

    int n_pass  = 0;
    int n_total = 0;
    int mem_lat = 1;
    int cyc     = 0;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .pc_req_i      (pc_req_i),
        .pc_ack_o      (pc_ack_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_err_o   (instr_err_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'h0020_81B3;
            default:       return 32'hA500_0000 ^ a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    endtask

    // Instruction memory: in-order responses mem_lat cycles after each grant, cleared by reset.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    mreq_t mtmp;
    always begin
        @(negedge clk);
        if (!rst_n) begin
            mq.delete();
        end else if (imem_req_o && imem_gnt_i) begin
            mtmp.addr = imem_addr_o;
            mtmp.due  = cyc + mem_lat;
            mq.push_back(mtmp);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
    end

    // Reference model: buffered entries, in-flight PCs and a discard count, checked every cycle.
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic err; } ent_t;
    ent_t        m_fifo[$];
    logic [31:0] m_infl[$];
    int          m_discard = 0;

    always @(negedge clk) begin : model
        logic aligned, space, e_req, e_mis, e_ack, e_valid;
        ent_t e;
        aligned = (pc_i[1:0] == 2'b00);
        space   = (m_fifo.size() + m_infl.size() + m_discard) < DEPTH;
        e_req   = rst_n && pc_req_i && space && !flush_i && aligned;
        e_mis   = rst_n && pc_req_i && space && !flush_i && !aligned
                  && m_infl.size() == 0 && m_discard == 0;
        e_ack   = (e_req && imem_gnt_i) || e_mis;
        e_valid = rst_n && m_fifo.size() > 0;
        chk1("m_imem_req", imem_req_o, e_req);
        chk1("m_pc_ack", pc_ack_o, e_ack);
        chk1("m_instr_valid", instr_valid_o, e_valid);
        if (e_req) chk("m_imem_addr", imem_addr_o, pc_i);
        if (e_valid) begin
            chk("m_instr", instr_o, m_fifo[0].instr);
            chk("m_instr_pc", instr_pc_o, m_fifo[0].pc);
            chk1("m_instr_err", instr_err_o, m_fifo[0].err);
        end
        if (!rst_n) begin
            m_fifo.delete();
            m_infl.delete();
            m_discard = 0;
        end else if (flush_i) begin
            if (imem_rvalid_i && (m_discard + m_infl.size()) > 0)
                m_discard = m_discard + m_infl.size() - 1;
            else
                m_discard = m_discard + m_infl.size();
            m_fifo.delete();
            m_infl.delete();
        end else begin
            if (e_valid && instr_ready_i) void'(m_fifo.pop_front());
            if (imem_rvalid_i) begin
                if (m_discard > 0) begin
                    m_discard--;
                end else if (m_infl.size() > 0) begin
                    e.instr = imem_rdata_i;
                    e.pc    = m_infl.pop_front();
                    e.err   = 1'b0;
                    m_fifo.push_back(e);
                end
            end
            if (e_req && imem_gnt_i) m_infl.push_back(pc_i);
            if (e_mis) begin
                e.instr = 32'h0;
                e.pc    = pc_i;
                e.err   = 1'b1;
                m_fifo.push_back(e);
            end
        end
    end

    task automatic step(input logic rst, input logic req, input logic [31:0] pc,
                        input logic fl, input logic gnt, input logic rdy);
        @(posedge clk);
        #1;
        rst_n         = rst;
        pc_req_i      = req;
        pc_i          = pc;
        flush_i       = fl;
        imem_gnt_i    = gnt;
        instr_ready_i = rdy;
        #3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        // Reset held with a pending PC request
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
            chk1("rst_req", imem_req_o, 1'b0);
            chk1("rst_ack", pc_ack_o, 1'b0);
            chk1("rst_valid", instr_valid_o, 1'b0);
        end

        // Stream 0x0, 0x4, 0x8 with one-cycle memory latency
        step(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);  chk1("s_ack0", pc_ack_o, 1'b1);
        step(1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1);  chk1("s_ack4", pc_ack_o, 1'b1);
        step(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1);
        chk("s_instr0", instr_o, 32'h0050_0093);
        chk("s_pc0", instr_pc_o, 32'h0);
        chk1("s_nospace", imem_req_o, 1'b0);
        step(1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1);
        chk("s_instr1", instr_o, 32'h0010_0113);
        chk("s_pc1", instr_pc_o, 32'h4);
        chk1("s_ack8", pc_ack_o, 1'b1);
        step(1'b1, 1'b0, 32'h8, 1'b0, 1'b1, 1'b1);  chk1("s_nobypass", instr_valid_o, 1'b0);
        step(1'b1, 1'b0, 32'h8, 1'b0, 1'b1, 1'b1);
        chk("s_instr2", instr_o, 32'h0020_81B3);
        chk("s_pc2", instr_pc_o, 32'h8);
        chk1("s_err2", instr_err_o, 1'b0);

        // Backpressure: decoder stalls, credit runs out after two acks
        step(1'b1, 1'b1, 32'h0C, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0);  chk1("bp_req_off0", imem_req_o, 1'b0);
        step(1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0);  chk1("bp_req_off1", imem_req_o, 1'b0);
        step(1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 1'b1);
        chk1("bp_pop_no_credit", imem_req_o, 1'b0);
        chk("bp_head_pc", instr_pc_o, 32'h0C);
        chk("bp_head_instr", instr_o, 32'hA500_000C);
        step(1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0);
        chk1("bp_req_back", imem_req_o, 1'b1);
        chk("bp_next_pc", instr_pc_o, 32'h10);
        step(1'b1, 1'b0, 32'h14, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h14, 1'b0, 1'b1, 1'b1);  chk("bp_last_pc", instr_pc_o, 32'h14);

        // Flush with two requests in flight (three-cycle latency)
        mem_lat = 3;
        step(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1);  chk1("f_ack10", pc_ack_o, 1'b1);
        step(1'b1, 1'b1, 32'h14, 1'b0, 1'b1, 1'b1);  chk1("f_ack14", pc_ack_o, 1'b1);
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
        chk1("f_req_flush", imem_req_o, 1'b0);
        chk1("f_ack_flush", pc_ack_o, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1);  chk1("f_discard_credit", imem_req_o, 1'b0);
        step(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1);  chk1("f_ack100", pc_ack_o, 1'b1);
        step(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1);  chk1("f_dropped0", instr_valid_o, 1'b0);
        step(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1);  chk1("f_dropped1", instr_valid_o, 1'b0);
        step(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 1'b1);
        chk("f_first_pc", instr_pc_o, 32'h100);
        chk("f_first_instr", instr_o, 32'hA500_0100);
        mem_lat = 1;

        // Misaligned fetch with nothing outstanding
        step(1'b1, 1'b1, 32'h102, 1'b0, 1'b1, 1'b1);
        chk1("m_noreq", imem_req_o, 1'b0);
        chk1("m_ack", pc_ack_o, 1'b1);
        step(1'b1, 1'b0, 32'h102, 1'b0, 1'b1, 1'b1);
        chk1("m_valid", instr_valid_o, 1'b1);
        chk1("m_err", instr_err_o, 1'b1);
        chk("m_pc", instr_pc_o, 32'h102);
        chk("m_instr_zero", instr_o, 32'h0);

        // Misaligned fetch held off while a request is outstanding
        step(1'b1, 1'b1, 32'h30, 1'b0, 1'b1, 1'b1);   chk1("mb_ack30", pc_ack_o, 1'b1);
        step(1'b1, 1'b1, 32'h106, 1'b0, 1'b1, 1'b1);  chk1("mb_blocked", pc_ack_o, 1'b0);
        step(1'b1, 1'b1, 32'h106, 1'b0, 1'b1, 1'b1);
        chk1("mb_ack", pc_ack_o, 1'b1);
        chk("mb_head_pc", instr_pc_o, 32'h30);
        step(1'b1, 1'b0, 32'h106, 1'b0, 1'b1, 1'b1);
        chk1("mb_err", instr_err_o, 1'b1);
        chk("mb_pc", instr_pc_o, 32'h106);

        // Grant stall: request and address held for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
            chk1("g_req", imem_req_o, 1'b1);
            chk("g_addr", imem_addr_o, 32'h20);
            chk1("g_noack", pc_ack_o, 1'b0);
        end
        step(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1);  chk1("g_ack", pc_ack_o, 1'b1);
        step(1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 1'b1);
        chk("g_pc", instr_pc_o, 32'h20);
        chk("g_instr", instr_o, 32'hA500_0020);

        // Flush in the same cycle as a response; refetch while a discard is pending
        mem_lat = 2;
        step(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1);  chk1("fr_rvalid_at_flush", imem_rvalid_i, 1'b1);
        step(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1);  chk1("fr_ack_during_discard", pc_ack_o, 1'b1);
        step(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 1'b1);  chk1("fr_empty", instr_valid_o, 1'b0);
        step(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 1'b1);
        chk1("fr_valid", instr_valid_o, 1'b1);
        chk("fr_pc", instr_pc_o, 32'h200);
        chk("fr_instr", instr_o, 32'hA500_0200);
        mem_lat = 1;

        // Reset in the middle of operation clears the buffered entry
        step(1'b1, 1'b1, 32'h50, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h50, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h50, 1'b0, 1'b1, 1'b0);  chk1("mr_buffered", instr_valid_o, 1'b1);
        step(1'b0, 1'b0, 32'h50, 1'b0, 1'b1, 1'b0);  chk1("mr_in_reset", instr_valid_o, 1'b0);
        step(1'b1, 1'b0, 32'h50, 1'b0, 1'b1, 1'b0);  chk1("mr_cleared", instr_valid_o, 1'b0);
        step(1'b1, 1'b1, 32'h60, 1'b0, 1'b1, 1'b1);  chk1("mr_ack60", pc_ack_o, 1'b1);
        step(1'b1, 1'b0, 32'h60, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 32'h60, 1'b0, 1'b1, 1'b1);  chk("mr_pc60", instr_pc_o, 32'h60);
        step(1'b1, 1'b0, 32'h60, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
